// File: rtl/wshbn_master.sv
// wshbn_master: single-beat Wishbone master bridging a memory controller's
// word read/write requests onto a classic Wishbone bus. One transfer at a
// time: IDLE accepts a request, BUS holds cyc/stb until ack, err or
// timeout, and RESP emits a one-cycle completion strobe before going idle.
module wshbn_master #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [29:0] req_addr,
  input  logic [31:0] req_data,
  output logic [31:0] rd_data,
  output logic        busy,
  output logic        data_av,
  output logic        err,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [31:0] wb_dat_o,
  output logic [3:0]  wb_sel_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);

  // Counter wide enough to hold TIMEOUT_CYCLES, never narrower than 1 bit.
  localparam int CW = (TIMEOUT_CYCLES > 0) ? (($clog2(TIMEOUT_CYCLES + 1) > 0) ?
                      $clog2(TIMEOUT_CYCLES + 1) : 1) : 1;
  localparam logic [CW-1:0] TO_LAST_C = CW'((TIMEOUT_CYCLES > 0) ? (TIMEOUT_CYCLES - 1) : 0);
  localparam logic [CW-1:0] CNT_MAX_C = {CW{1'b1}};
  localparam logic [CW-1:0] CNT_ONE_C = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic            start_s;
  logic            done_s;
  logic            fail_s;
  logic            timeout_hit_s;
  logic            we_next_s;

  logic            we_r;
  logic [29:0]     addr_r;
  logic [31:0]     data_r;
  logic [CW-1:0]   cnt_r;
  logic [31:0]     rd_data_r;
  logic            cyc_r;
  logic            we_out_r;
  logic            data_av_r;
  logic            err_r;

  // Timeout fires on the last permitted BUS cycle; a zero parameter disables it.
  always_comb begin
    timeout_hit_s = 1'b0;
    if ((TIMEOUT_CYCLES != 0) && (cnt_r == TO_LAST_C)) begin
      timeout_hit_s = 1'b1;
    end else begin
      timeout_hit_s = 1'b0;
    end
  end

  // Next-state and transfer event decode.
  always_comb begin
    state_next_s = state_r;
    start_s      = 1'b0;
    done_s       = 1'b0;
    fail_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        // Exactly one request direction; both or neither is ignored.
        if (req_rd ^ req_wr) begin
          state_next_s = ST_BUS;
          start_s      = 1'b1;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_BUS: begin
        // Slave error wins over a simultaneous ack.
        if (wb_err_i) begin
          state_next_s = ST_RESP;
          done_s       = 1'b1;
          fail_s       = 1'b1;
        end else if (wb_ack_i) begin
          state_next_s = ST_RESP;
          done_s       = 1'b1;
        end else if (timeout_hit_s) begin
          state_next_s = ST_RESP;
          done_s       = 1'b1;
          fail_s       = 1'b1;
        end else begin
          state_next_s = ST_BUS;
        end
      end
      ST_RESP: begin
        // Always back to IDLE so a still-held request is not replayed here.
        state_next_s = ST_IDLE;
      end
      default: begin
        state_next_s = ST_IDLE;
      end
    endcase
  end

  // Direction for the upcoming BUS phase: fresh on acceptance, else held.
  always_comb begin
    we_next_s = we_r;
    if (start_s) begin
      we_next_s = req_wr;
    end else begin
      we_next_s = we_r;
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Latch address, data and direction when a request is accepted.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_r   <= 1'b0;
      addr_r <= 30'h0000_0000;
      data_r <= 32'h0000_0000;
    end else if (start_s) begin
      we_r   <= req_wr;
      addr_r <= req_addr;
      data_r <= req_data;
    end
  end

  // BUS cycle counter: cleared on entry, saturating rather than wrapping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r <= {CW{1'b0}};
    end else if (start_s) begin
      cnt_r <= {CW{1'b0}};
    end else if ((state_r == ST_BUS) && (cnt_r != CNT_MAX_C)) begin
      cnt_r <= cnt_r + CNT_ONE_C;
    end
  end

  // Read data capture: slave data on a good read, zero on a failed read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_data_r <= 32'h0000_0000;
    end else if (done_s && !we_r) begin
      rd_data_r <= fail_s ? 32'h0000_0000 : wb_dat_i;
    end
  end

  // Registered bus control and completion strobes, derived from next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_r     <= 1'b0;
      we_out_r  <= 1'b0;
      data_av_r <= 1'b0;
      err_r     <= 1'b0;
    end else begin
      cyc_r     <= (state_next_s == ST_BUS);
      we_out_r  <= (state_next_s == ST_BUS) && we_next_s;
      data_av_r <= done_s;
      err_r     <= fail_s;
    end
  end

  assign rd_data  = rd_data_r;
  assign busy     = cyc_r;
  assign data_av  = data_av_r;
  assign err      = err_r;
  assign wb_cyc_o = cyc_r;
  assign wb_stb_o = cyc_r;
  assign wb_we_o  = we_out_r;
  assign wb_adr_o = {addr_r, 2'b00};
  assign wb_dat_o = data_r;
  assign wb_sel_o = 4'hF;

endmodule

// File: tb/tb_wshbn_master.sv
// Directed bench for wshbn_master: read, zero-wait write, error priority,
// timeout, illegal request and reset during a transfer.
module tb_wshbn_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_rd = 1'b0;
  logic        req_wr = 1'b0;
  logic [29:0] req_addr = 30'h0;
  logic [31:0] req_data = 32'h0;
  logic [31:0] rd_data;
  logic        busy;
  logic        data_av;
  logic        err;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [31:0] wb_adr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_i = 32'h0;
  logic        wb_ack_i = 1'b0;
  logic        wb_err_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;
  int cyc_rises = 0;
  int rises_before;

  wshbn_master #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_wr(req_wr),
    .req_addr(req_addr), .req_data(req_data), .rd_data(rd_data),
    .busy(busy), .data_av(data_av), .err(err),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  // Count issued bus cycles.
  always @(posedge wb_cyc_o) cyc_rises <= cyc_rises + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_cyc"}, wb_cyc_o, 1'b0);
    chk1({tag, "_stb"}, wb_stb_o, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_we"}, wb_we_o, 1'b0);
  endtask

  initial begin
    // Reset state
    #2;
    chk_idle("rst");
    chk1("rst_dav", data_av, 1'b0);
    chk1("rst_err", err, 1'b0);
    chk32("rst_rdd", rd_data, 32'h0000_0000);
    chk32("rst_adr", wb_adr_o, 32'h0000_0000);
    chk32("rst_dat", wb_dat_o, 32'h0000_0000);
    chk32("rst_sel", {28'h0, wb_sel_o}, 32'h0000_000F);
    step();
    step();
    rst = 1'b1;

    // Read, ack in third BUS cycle
    req_rd = 1'b1; req_addr = 30'h0000_0100; wb_dat_i = 32'hCAFE_0001;
    step();
    req_rd = 1'b0;
    chk1("rd_cyc", wb_cyc_o, 1'b1);
    chk1("rd_stb", wb_stb_o, 1'b1);
    chk1("rd_busy1", busy, 1'b1);
    chk1("rd_we", wb_we_o, 1'b0);
    chk32("rd_adr", wb_adr_o, 32'h0000_0400);
    step();
    chk1("rd_busy2", busy, 1'b1);
    chk1("rd_dav2", data_av, 1'b0);
    step();
    chk1("rd_busy3", busy, 1'b1);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk1("rd_dav", data_av, 1'b1);
    chk1("rd_err", err, 1'b0);
    chk32("rd_data", rd_data, 32'hCAFE_0001);
    chk_idle("rd_resp");
    step();
    chk1("rd_dav_off", data_av, 1'b0);
    chk32("rd_hold", rd_data, 32'hCAFE_0001);

    // Write, zero-wait ack, top of address space
    req_wr = 1'b1; req_data = 32'h1234_5678; req_addr = 30'h3FFF_FFFF;
    wb_dat_i = 32'hFFFF_0000;
    step();
    req_wr = 1'b0;
    chk1("wr_cyc", wb_cyc_o, 1'b1);
    chk1("wr_we", wb_we_o, 1'b1);
    chk32("wr_dat", wb_dat_o, 32'h1234_5678);
    chk32("wr_adr", wb_adr_o, 32'hFFFF_FFFC);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk1("wr_dav", data_av, 1'b1);
    chk1("wr_err", err, 1'b0);
    chk32("wr_rdd", rd_data, 32'hCAFE_0001);
    chk_idle("wr_resp");
    step();
    chk1("wr_dav_off", data_av, 1'b0);

    // Error takes priority over simultaneous ack on a read
    req_rd = 1'b1; req_addr = 30'h0000_0005; wb_dat_i = 32'hDEAD_BEEF;
    step();
    req_rd = 1'b0;
    chk32("ep_adr", wb_adr_o, 32'h0000_0014);
    wb_ack_i = 1'b1; wb_err_i = 1'b1;
    step();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    chk1("ep_dav", data_av, 1'b1);
    chk1("ep_err", err, 1'b1);
    chk32("ep_rdd", rd_data, 32'h0000_0000);
    step();
    chk1("ep_err_off", err, 1'b0);

    // Zero-wait read to load a nonzero rd_data
    req_rd = 1'b1; req_addr = 30'h0000_0010; wb_dat_i = 32'hA5A5_A5A5;
    step();
    req_rd = 1'b0;
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk32("zr_rdd", rd_data, 32'hA5A5_A5A5);
    step();

    // Timeout: 16 BUS cycles with no response
    req_rd = 1'b1; req_addr = 30'h0000_0020; wb_dat_i = 32'h0000_0055;
    step();
    req_rd = 1'b0;
    chk1("to_cyc1", wb_cyc_o, 1'b1);
    for (int i = 2; i <= 16; i++) begin
      step();
      chk1("to_cyc_hold", wb_cyc_o, 1'b1);
    end
    step();
    chk1("to_stb_drop", wb_stb_o, 1'b0);
    chk1("to_dav", data_av, 1'b1);
    chk1("to_err", err, 1'b1);
    chk32("to_rdd", rd_data, 32'h0000_0000);
    step();
    chk1("to_dav_off", data_av, 1'b0);
    chk1("to_err_off", err, 1'b0);
    chk_idle("to_idle");

    // Illegal: both requests high
    req_rd = 1'b1; req_wr = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk1("ill_cyc", wb_cyc_o, 1'b0);
      chk1("ill_busy", busy, 1'b0);
    end
    req_rd = 1'b0; req_wr = 1'b0;

    // Reload rd_data, then reset in the middle of a transfer
    req_rd = 1'b1; req_addr = 30'h0000_0030; wb_dat_i = 32'h0F0F_1234;
    step();
    req_rd = 1'b0;
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk32("pre_rdd", rd_data, 32'h0F0F_1234);
    step();
    req_rd = 1'b1; req_addr = 30'h0000_0007;
    step();
    req_rd = 1'b0;
    chk1("mr_cyc", wb_cyc_o, 1'b1);
    rst = 1'b0;
    #1;
    chk1("mr_cyc_fall", wb_cyc_o, 1'b0);
    chk1("mr_stb_fall", wb_stb_o, 1'b0);
    chk1("mr_busy", busy, 1'b0);
    chk32("mr_rdd", rd_data, 32'h0000_0000);
    chk32("mr_adr", wb_adr_o, 32'h0000_0000);
    wb_ack_i = 1'b1;
    step();
    chk1("mr_dav1", data_av, 1'b0);
    step();
    chk1("mr_dav2", data_av, 1'b0);
    wb_ack_i = 1'b0;
    rst = 1'b1;

    // Request held through RESP: exactly one bus cycle issued
    rises_before = cyc_rises;
    req_rd = 1'b1; req_addr = 30'h0000_0009; wb_dat_i = 32'h0BAD_F00D;
    step();
    chk1("hr_cyc", wb_cyc_o, 1'b1);
    chk32("hr_adr", wb_adr_o, 32'h0000_0024);
    wb_ack_i = 1'b1;
    step();
    wb_ack_i = 1'b0;
    chk1("hr_dav", data_av, 1'b1);
    chk32("hr_rdd", rd_data, 32'h0BAD_F00D);
    step();
    req_rd = 1'b0;
    chk1("hr_idle_cyc", wb_cyc_o, 1'b0);
    chk1("hr_dav_off", data_av, 1'b0);
    step();
    step();
    chk1("hr_still_idle", wb_cyc_o, 1'b0);
    chk32("hr_rises", 32'(cyc_rises - rises_before), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/wshbn_master.md
WSHBN_MASTER -- requirements
Module: wshbn_master

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 16, the maximum number of cycles spent in BUS before the transfer is aborted; 0 disables the timeout.
REQ-002 clk  input  1  single clock; all state changes on the rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 req_rd  input  1  read request (driven by the memory controller's wshbn_rd).
REQ-005 req_wr  input  1  write request (driven by wshbn_wr).
REQ-006 req_addr  input  30  word address (from wshbn_addr_o).
REQ-007 req_data  input  32  write data (from wshbn_data_o).
REQ-008 rd_data  output  32  read data returned to the controller (its wshbn_data_i).
REQ-009 busy  output  1  transfer in progress (to wshbn_busy).
REQ-010 data_av  output  1  one-cycle completion strobe (to wshbn_data_av).
REQ-011 err  output  1  one-cycle error strobe, coincident with data_av.
REQ-012 wb_cyc_o, wb_stb_o, wb_we_o  output  1 each  Wishbone cycle, strobe and write-enable.
REQ-013 wb_adr_o  output  32  byte address, {latched addr, 2'b00}.
REQ-014 wb_dat_o  output  32  latched write data.
REQ-015 wb_sel_o  output  4  byte selects; constant 4'hF, word access only.
REQ-016 wb_dat_i  input  32  slave read data.
REQ-017 wb_ack_i, wb_err_i  input  1 each  slave acknowledge and slave error.

Function
REQ-018 The FSM SHALL have three states: IDLE, BUS and RESP.
REQ-019 IDLE: when exactly one of req_rd/req_wr is 1 at a clock edge, the block SHALL latch req_addr, req_data and we=req_wr, then move to BUS.
- Both requests high or both low: no action.
REQ-020 BUS: wb_cyc_o=wb_stb_o=1 and busy=1; wb_we_o, wb_adr_o and wb_dat_o come from the latched values and are stable for the whole state.
REQ-021 BUS: on wb_ack_i=1 the block SHALL move to RESP.
- If we=0, rd_data <= wb_dat_i at that same edge.
- An ack in the first BUS cycle is legal, giving a minimum latency of request edge to data_av of 2 cycles.
REQ-022 BUS: on wb_err_i=1 the block SHALL move to RESP with err set; this takes priority when wb_ack_i=1 in the same cycle.
- On a read error, rd_data <= 32'h0000_0000.
REQ-023 Timeout: a counter SHALL clear on entry to BUS and increment each BUS cycle.
- When it reaches TIMEOUT_CYCLES-1 with no ack and no err, the block SHALL go to RESP as an error, exactly as REQ-022.
- Counter width SHALL be $clog2(TIMEOUT_CYCLES+1), minimum 1; it does not wrap.
REQ-024 RESP lasts exactly one cycle:
- data_av=1, busy=0, wb_cyc_o=wb_stb_o=0; err=1 only if the transfer errored.
- The next state SHALL be IDLE unconditionally, so the still-asserted request of the completing access is never re-issued.
REQ-025 Outside BUS: wb_cyc_o, wb_stb_o and busy SHALL be 0, and wb_we_o SHALL be 0.
REQ-026 rd_data SHALL hold its value except at a read completion (REQ-021/022); write completions leave it unchanged.
REQ-027 Requests arriving while in BUS or RESP SHALL be ignored, not queued.

Reset
REQ-028 On rst=0, asynchronously and regardless of state, the block SHALL:
- go to IDLE;
- drive wb_cyc_o=wb_stb_o=wb_we_o=0, busy=0, data_av=0, err=0;
- clear rd_data, the latched address/data and the timeout counter to 0.
- A transfer in flight is abandoned with no data_av.
REQ-029 After rst returns to 1, the first clock edge SHALL be able to accept a request.

Verification
REQ-030 Read, ack after 3 BUS cycles: req_rd=1, req_addr=30'h0000_0100, wb_dat_i=32'hCAFE_0001 -> wb_adr_o=32'h0000_0400, we=0, busy=1 for 3 cycles, then data_av=1 for 1 cycle, rd_data=32'hCAFE_0001, err=0.
REQ-031 Write, zero-wait ack: req_wr=1, req_data=32'h1234_5678, ack in first BUS cycle -> wb_we_o=1, wb_dat_o=32'h1234_5678, data_av 2 cycles after request edge, rd_data unchanged.
REQ-032 Error priority: wb_ack_i=1 and wb_err_i=1 together on a read -> data_av=1, err=1, rd_data=0.
REQ-033 Timeout: TIMEOUT_CYCLES=16, no ack -> stb dropped after 16 BUS cycles, data_av=err=1 for 1 cycle, then IDLE.
REQ-034 Reset mid-transfer: rst=0 during BUS -> wb_cyc_o/wb_stb_o fall before the next clock edge, and no data_av is produced. Then, with req_rd held high through RESP, exactly one bus cycle is issued.
REQ-035 Illegal request: req_rd=req_wr=1 -> no wb_cyc_o, busy=0.
